// File: rtl/uart_report_scheduler_pkg.sv
// Shared definitions for the UART report scheduler: FSM encoding, frame
// layout, ASCII constants and default command codes.
package uart_report_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_ACC,
    WAIT_RDY,
    DONE
  } state_t;

  localparam int FRAME_LEN = 11;
  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  localparam logic [7:0] ASCII_H     = 8'h48;
  localparam logic [7:0] ASCII_T     = 8'h54;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_DASH  = 8'h2D;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  localparam logic [7:0] DEF_CMD_REQ = 8'h3F;
  localparam logic [7:0] DEF_CMD_ON  = 8'h31;
  localparam logic [7:0] DEF_CMD_OFF = 8'h30;

  // Invalid BCD (10..15) is shown as '-' so a bad sensor read is visible.
  function automatic logic [7:0] bcd_to_ascii(input logic [3:0] d);
    return (d > 4'd9) ? ASCII_DASH : (ASCII_ZERO | {4'h0, d});
  endfunction

endpackage

// File: rtl/uart_report_scheduler_byte_mux.sv
// Combinational frame byte selector: "H:hh T:tt\r\n" indexed 0..10.
module report_byte_mux
  import uart_report_scheduler_pkg::*;
(
  input  logic [3:0] index,
  input  logic [3:0] h10,
  input  logic [3:0] h0,
  input  logic [3:0] t10,
  input  logic [3:0] t0,
  output logic [7:0] tx_byte
);

  always_comb begin
    tx_byte = 8'h00;
    case (index)
      4'd0:    tx_byte = ASCII_H;
      4'd1:    tx_byte = ASCII_COLON;
      4'd2:    tx_byte = bcd_to_ascii(h10);
      4'd3:    tx_byte = bcd_to_ascii(h0);
      4'd4:    tx_byte = ASCII_SPACE;
      4'd5:    tx_byte = ASCII_T;
      4'd6:    tx_byte = ASCII_COLON;
      4'd7:    tx_byte = bcd_to_ascii(t10);
      4'd8:    tx_byte = bcd_to_ascii(t0);
      4'd9:    tx_byte = ASCII_CR;
      4'd10:   tx_byte = ASCII_LF;
      default: tx_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/uart_report_scheduler.sv
// Sends humidity/temperature report frames over a UART, on command or
// periodically. Handshake: tx_send pulses only while tx_trdy=1 in SEND;
// the transmitter acknowledges by dropping tx_trdy, then raises it when free.
module uart_report_scheduler
  import uart_report_scheduler_pkg::*;
#(
  parameter int         PERIOD_TICKS = 2000000,
  parameter logic [7:0] CMD_REQ      = DEF_CMD_REQ,
  parameter logic [7:0] CMD_ON       = DEF_CMD_ON,
  parameter logic [7:0] CMD_OFF      = DEF_CMD_OFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] humidity10,
  input  logic [3:0] humidity0,
  input  logic [3:0] temperature10,
  input  logic [3:0] temperature0,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_read_en,
  input  logic       tx_trdy,
  output logic [7:0] tx_data,
  output logic       tx_send,
  output logic       busy,
  output logic       auto_en,
  output logic       frame_done,
  output state_t     dbg_state
);

  localparam int CNT_W = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD_TICKS - 1);

  state_t           state, state_nxt;
  logic [3:0]       idx;
  logic [3:0]       h10_q, h0_q, t10_q, t0_q;
  logic             pending;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       tx_data_q;
  logic [7:0]       mux_byte;
  logic             consume, tick, trigger;

  assign consume = rx_valid && !rx_read_en;
  assign tick    = auto_en && (cnt == CNT_MAX);
  assign trigger = tick || (consume && (rx_data == CMD_REQ));

  report_byte_mux u_byte_mux (
    .index   (idx),
    .h10     (h10_q),
    .h0      (h0_q),
    .t10     (t10_q),
    .t0      (t0_q),
    .tx_byte (mux_byte)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_send   = 1'b0;
    case (state)
      IDLE:     if (pending) state_nxt = LOAD;
      LOAD:     state_nxt = SEND;
      SEND: begin
        if (tx_trdy) begin
          tx_send   = 1'b1;
          state_nxt = WAIT_ACC;
        end
      end
      WAIT_ACC: if (!tx_trdy) state_nxt = WAIT_RDY;
      WAIT_RDY: if (tx_trdy) state_nxt = (idx == LAST_IDX) ? DONE : SEND;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);
  assign tx_data    = (state == SEND) ? mux_byte : tx_data_q;
  assign dbg_state  = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      idx        <= 4'd0;
      h10_q      <= 4'd0;
      h0_q       <= 4'd0;
      t10_q      <= 4'd0;
      t0_q       <= 4'd0;
      pending    <= 1'b0;
      cnt        <= '0;
      auto_en    <= 1'b1;
      tx_data_q  <= 8'h00;
      rx_read_en <= 1'b0;
    end else begin
      rx_read_en <= consume;

      if (state == LOAD) begin
        idx   <= 4'd0;
        h10_q <= humidity10;
        h0_q  <= humidity0;
        t10_q <= temperature10;
        t0_q  <= temperature0;
      end else if (state == WAIT_RDY && tx_trdy && idx != LAST_IDX) begin
        idx <= idx + 4'd1;
      end

      if (tx_send) tx_data_q <= mux_byte;

      // A new trigger wins over the clear, so one arriving while the
      // FSM leaves IDLE still produces a follow-up frame.
      if (trigger)            pending <= 1'b1;
      else if (state == IDLE) pending <= 1'b0;

      if (consume && rx_data == CMD_ON) begin
        auto_en <= 1'b1;
        cnt     <= '0;
      end else if (consume && rx_data == CMD_OFF) begin
        auto_en <= 1'b0;
        cnt     <= '0;
      end else if (!auto_en || tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_report_scheduler.sv
// Directed bench for uart_report_scheduler with a simple UART transmitter model.
module tb_uart_report_scheduler;
  import uart_report_scheduler_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] humidity10 = 4'd0, humidity0 = 4'd0, temperature10 = 4'd0, temperature0 = 4'd0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_read_en;
  logic       tx_trdy = 1'b1;
  logic [7:0] tx_data;
  logic       tx_send, busy, auto_en, frame_done;
  state_t     dbg_state;

  uart_report_scheduler #(.PERIOD_TICKS(1000)) dut (
    .clk(clk), .reset(reset),
    .humidity10(humidity10), .humidity0(humidity0),
    .temperature10(temperature10), .temperature0(temperature0),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_read_en(rx_read_en),
    .tx_trdy(tx_trdy), .tx_data(tx_data), .tx_send(tx_send),
    .busy(busy), .auto_en(auto_en), .frame_done(frame_done),
    .dbg_state(dbg_state)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // UART transmitter model: trdy low for 20 cycles after each tx_send
  int trdy_cnt = 0;
  always @(posedge clk) begin
    if (tx_send) begin
      tx_trdy  <= 1'b0;
      trdy_cnt <= 20;
    end else if (trdy_cnt > 1) begin
      trdy_cnt <= trdy_cnt - 1;
    end else if (trdy_cnt == 1) begin
      tx_trdy  <= 1'b1;
      trdy_cnt <= 0;
    end
  end

  // Monitor, sampled on the falling edge
  logic [7:0] cap_q[$];
  logic [7:0] exp_q[$];
  int load_q[$];
  int send_cnt = 0, fd_cnt = 0, rd_cnt = 0, consec = 0, load_cnt = 0, gap = 0;
  logic prev_rd = 1'b0;
  always @(negedge clk) begin
    if (!busy && fd_cnt == 1) gap++;
    if (tx_send) begin cap_q.push_back(tx_data); send_cnt++; end
    if (frame_done) fd_cnt++;
    if (rx_read_en) rd_cnt++;
    if (rx_read_en && prev_rd) consec++;
    prev_rd = rx_read_en;
    if (dbg_state == LOAD) begin load_cnt++; load_q.push_back(cyc); end
  end

  // Scoreboard
  int n_cmp = 0, n_fail = 0;
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [87:0] cap_frame(input int base);
    logic [87:0] r = '0;
    for (int i = 0; i < FRAME_LEN; i++)
      r = {r[79:0], (base + i < cap_q.size()) ? cap_q[base + i] : 8'h00};
    return r;
  endfunction

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    cap_q.delete(); load_q.delete();
    send_cnt = 0; fd_cnt = 0; rd_cnt = 0; consec = 0; load_cnt = 0; gap = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    step();
    rx_valid = 1'b0;
    step();
  endtask

  task automatic set_digits(input logic [3:0] a, b, c, d);
    humidity10 = a; humidity0 = b; temperature10 = c; temperature0 = d;
  endtask

  task automatic wait_fd(input int target, input int budget, input string name);
    for (int n = 0; n < budget && fd_cnt < target; n++) step();
    check(name, (fd_cnt >= target), 1);
  endtask

  task automatic wait_cap(input int target, input int budget, input string name);
    for (int n = 0; n < budget && cap_q.size() < target; n++) step();
    check(name, (cap_q.size() >= target), 1);
  endtask

  task automatic wait_load(input int target, input int budget, input string name);
    for (int n = 0; n < budget && load_cnt < target; n++) step();
    check(name, (load_cnt >= target), 1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    for (int n = 0; n < budget && busy; n++) step();
    check(name, busy, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tx_send"}, tx_send, 0);
    check({tag, "_tx_data"}, tx_data, 8'h00);
    check({tag, "_rx_read_en"}, rx_read_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_auto_en"}, auto_en, 1);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_state"}, dbg_state, IDLE);
  endtask

  // Table-driven frame vectors
  typedef struct {
    logic [3:0]  h10, h0, t10, t0;
    logic [87:0] exp_frame;
  } vec_t;
  vec_t vecs[4];

  initial begin
    int t0, diff, s0;
    logic [87:0] exp_f;

    vecs[0] = '{4'd4, 4'd5, 4'd2, 4'd7, 88'h48_3A_34_35_20_54_3A_32_37_0D_0A};
    vecs[1] = '{4'hA, 4'd0, 4'd9, 4'd9, 88'h48_3A_2D_30_20_54_3A_39_39_0D_0A};
    vecs[2] = '{4'd0, 4'd9, 4'hF, 4'd3, 88'h48_3A_30_39_20_54_3A_2D_33_0D_0A};
    vecs[3] = '{4'd9, 4'd9, 4'd0, 4'd0, 88'h48_3A_39_39_20_54_3A_30_30_0D_0A};

    // Reset
    repeat (3) step();
    reset = 1'b0;
    check_reset_vals("reset");

    // Periodic reports every 1000 cycles
    clear_mon();
    wait_load(3, 3500, "periodic_loads");
    diff = (load_q.size() >= 2) ? load_q[1] - load_q[0] : -1;
    check("period_1", diff, 1000);
    diff = (load_q.size() >= 3) ? load_q[2] - load_q[1] : -1;
    check("period_2", diff, 1000);

    // CMD_OFF: current frame finishes, then silence
    send_byte(DEF_CMD_OFF);
    wait_idle(600, "off_idle");
    check("off_auto_en", auto_en, 0);
    clear_mon();
    repeat (5000) step();
    check("off_no_frames", load_cnt, 0);

    // CMD_ON: next frame 1000 ticks after the counter clears
    clear_mon();
    t0 = cyc;
    send_byte(DEF_CMD_ON);
    check("on_auto_en", auto_en, 1);
    wait_load(1, 1200, "on_load");
    diff = (load_q.size() >= 1) ? load_q[0] - t0 : -1;
    check("on_delay", diff, 1002);
    send_byte(DEF_CMD_OFF);
    wait_idle(600, "on_off_idle");
    check("off_no_abort_bytes", cap_q.size(), 11);
    check("off_no_abort_done", fd_cnt, 1);

    // Directed frame vectors
    for (int v = 0; v < 4; v++) begin
      clear_mon();
      set_digits(vecs[v].h10, vecs[v].h0, vecs[v].t10, vecs[v].t0);
      send_byte(DEF_CMD_REQ);
      wait_fd(1, 800, $sformatf("vec%0d_done", v));
      repeat (5) step();
      check($sformatf("vec%0d_len", v), cap_q.size(), 11);
      check($sformatf("vec%0d_frame", v), cap_frame(0), vecs[v].exp_frame);
      check($sformatf("vec%0d_fd_pulses", v), fd_cnt, 1);
      check($sformatf("vec%0d_rd_pulses", v), rd_cnt, 1);
    end

    // Inputs changed mid-frame do not affect the frame
    clear_mon();
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    send_byte(DEF_CMD_REQ);
    wait_cap(3, 300, "snap_progress");
    set_digits(4'd8, 4'd8, 4'd8, 4'd8);
    wait_fd(1, 800, "snap_done");
    exp_q = '{8'h48, 8'h3A, 8'h31, 8'h32, 8'h20, 8'h54, 8'h3A, 8'h33, 8'h34, 8'h0D, 8'h0A};
    exp_f = '0;
    foreach (exp_q[i]) exp_f = {exp_f[79:0], exp_q[i]};
    check("snap_frame", cap_frame(0), exp_f);

    // Three CMD_REQ during a frame -> exactly one follow-up frame
    clear_mon();
    set_digits(4'd6, 4'd1, 4'd3, 4'd0);
    send_byte(DEF_CMD_REQ);
    wait_cap(2, 300, "multi_progress1");
    send_byte(DEF_CMD_REQ);
    wait_cap(4, 300, "multi_progress2");
    send_byte(DEF_CMD_REQ);
    send_byte(DEF_CMD_REQ);
    wait_fd(2, 1500, "multi_done");
    repeat (300) step();
    exp_f = 88'h48_3A_36_31_20_54_3A_33_30_0D_0A;
    check("multi_frames", fd_cnt, 2);
    check("multi_bytes", cap_q.size(), 22);
    check("multi_frame1", cap_frame(0), exp_f);
    check("multi_frame2", cap_frame(11), exp_f);
    check("multi_busy_gap", gap, 1);

    // Reset in the middle of byte 5
    clear_mon();
    set_digits(4'd4, 4'd5, 4'd2, 4'd7);
    send_byte(DEF_CMD_REQ);
    wait_cap(5, 300, "rst_progress");
    s0 = send_cnt;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check_reset_vals("midrst");
    repeat (30) step();
    check("midrst_no_send", send_cnt, s0);
    clear_mon();
    send_byte(DEF_CMD_REQ);
    wait_fd(1, 800, "midrst_frame_done");
    repeat (3) step();
    check("midrst_len", cap_q.size(), 11);
    check("midrst_frame", cap_frame(0), vecs[0].exp_frame);
    send_byte(DEF_CMD_OFF);
    wait_idle(600, "midrst_off_idle");

    // rx_valid held high with an unknown command byte
    clear_mon();
    rx_valid = 1'b1; rx_data = 8'h78;
    repeat (10) step();
    rx_valid = 1'b0;
    repeat (3) step();
    check("rx_pulses", rd_cnt, 5);
    check("rx_alternate", consec, 0);
    check("rx_no_frame", load_cnt, 0);
    check("rx_state", dbg_state, IDLE);
    check("rx_auto_en", auto_en, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_report_scheduler.md
UART_REPORT_SCHEDULER -- requirements
Module: uart_report_scheduler

Interface
REQ-001 SHALL have parameter PERIOD_TICKS, default 2000000, clk cycles between automatic reports (2 s at 1 MHz).
REQ-002 SHALL have parameter CMD_REQ, default 8'h3F ('?'), the command for an immediate report.
REQ-003 SHALL have parameter CMD_ON, default 8'h31 ('1'), the command to enable periodic reports.
REQ-004 SHALL have parameter CMD_OFF, default 8'h30 ('0'), the command to disable periodic reports.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have ports:
- clk  in  1  1 MHz system clock
- reset  in  1  synchronous, active-high
- humidity10, humidity0, temperature10, temperature0  in  4 each  BCD digits from DHT11
- rx_valid  in  1  UART receive byte available
- rx_data  in  8  UART receive byte
- rx_read_en  out  1  one-cycle consume pulse to UART
- tx_trdy  in  1  UART transmitter ready, synchronous to clk
- tx_data  out  8  byte to transmit
- tx_send  out  1  one-cycle transmit strobe
- busy  out  1  frame in progress
- auto_en  out  1  periodic reporting enabled
- frame_done  out  1  one-cycle pulse after the last byte completes

Function
REQ-007 Frame SHALL be 11 bytes: 'H' ':' h10 h0 ' ' 'T' ':' t10 t0 0x0D 0x0A.
REQ-008 Digits 0-9 SHALL map to 0x30+d; a BCD value above 9 SHALL be sent as '-' (0x2D).
REQ-009 All four BCD inputs SHALL be snapshotted in the LOAD cycle; later input changes SHALL NOT affect the frame in flight.
REQ-010 FSM states SHALL be IDLE, LOAD, SEND, WAIT_ACC, WAIT_RDY and DONE.
REQ-011 IDLE->LOAD when a trigger is pending. LOAD->SEND with byte index 0.
REQ-012 SEND: when tx_trdy=1, assert tx_send for exactly 1 cycle with tx_data valid that cycle, then go to WAIT_ACC.
REQ-013 WAIT_ACC: wait for tx_trdy=0, then go to WAIT_RDY.
REQ-014 WAIT_RDY: wait for tx_trdy=1, then go to SEND with index+1, or to DONE if index=10.
REQ-015 DONE SHALL last 1 cycle, pulse frame_done, and return to IDLE.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 Outside SEND, tx_send SHALL be 0 and tx_data SHALL hold its last value.
REQ-018 Receive acceptance:
- A byte is consumed in a cycle with rx_valid=1 and rx_read_en=0.
- rx_read_en SHALL pulse in the following cycle for exactly 1 cycle.
- rx_valid SHALL be ignored during that pulse cycle.
REQ-019 Consumed byte effects:
- CMD_REQ sets pending.
- CMD_ON sets auto_en=1 and clears the period counter.
- CMD_OFF sets auto_en=0 and clears the period counter.
- Any other byte is consumed and ignored.
REQ-020 Period counter:
- Counts 0..PERIOD_TICKS-1 while auto_en=1 and wraps.
- Sets pending on wrap.
- Holds 0 while auto_en=0.
- Keeps counting during a frame.
REQ-021 pending SHALL be a single flag, cleared on entry to LOAD.
- A trigger arriving during a frame sets it, giving exactly one follow-up frame.
- Multiple triggers during a frame, or a simultaneous tick and CMD_REQ, SHALL yield one frame.
- A trigger arriving in the same cycle as LOAD SHALL remain pending.
REQ-022 CMD_OFF during a frame SHALL NOT abort that frame.
REQ-023 There is no WAIT_ACC timeout; a stuck tx_trdy holds the FSM.

Reset
REQ-024 On reset: state=IDLE, index=0, pending=0, counter=0, auto_en=1, tx_send=0, tx_data=8'h00, rx_read_en=0, busy=0, frame_done=0.
REQ-025 Reset asserted mid-frame SHALL abandon the frame: tx_send=0 from the next edge, and no further bytes are sent.

Structure
REQ-026 A shared package SHALL hold:
- the state encoding
- FRAME_LEN=11
- the ASCII constants (H, T, colon, space, CR, LF, dash)
- the default command codes
REQ-027 One sub-module, report_byte_mux, SHALL be used: combinational, mapping (index, snapshot digits) to a byte.
- All sequential logic SHALL stay in uart_report_scheduler.

Verification
REQ-028 Bench SHALL use PERIOD_TICKS=1000 and a UART model with trdy low for 20 cycles after each tx_send.
REQ-029 Digits 4,5,2,7 with CMD_REQ -> "H:45 T:27\r\n" (48 3A 34 35 20 54 3A 32 37 0D 0A); one frame_done pulse; rx_read_en pulsed once.
REQ-030 auto_en=1, idle bus -> a frame starts every 1000 cycles; CMD_OFF -> no frame within 5000 cycles; CMD_ON -> next frame 1000 cycles later.
REQ-031 Three CMD_REQ bytes during a frame -> exactly 2 frames total; busy stays continuous between them apart from the IDLE/LOAD gap.
REQ-032 humidity10=4'hA -> byte 2 is 0x2D; inputs changed mid-frame -> the frame still carries the LOAD-time values.
REQ-033 Reset asserted during byte 5 -> tx_send stays 0; after release, outputs match REQ-024 and the next trigger sends a full 11-byte frame.
REQ-034 rx_valid held high 10 cycles with 'x' -> rx_read_en pulses on alternate cycles; no frame and no state change.
